// File: rtl/pca_pkg.sv
// Shared types and index/width helpers for the conditional-probability engine.
// Table cells are row-major by phenotype; results are grouped by genotype.
package pca_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SUM,
      ST_LOAD,
      ST_ITER,
      ST_OUT
   } state_t;

   localparam int unsigned DEF_FRAC_BITS = 16;
   localparam logic [31:0] ONE           = 32'd1 << DEF_FRAC_BITS;

   // Column sums need at least one guard bit even for a single phenotype row.
   function automatic int unsigned sum_width(input int unsigned data_width,
                                             input int unsigned n_pheno);
      int unsigned extra;
      extra = (n_pheno > 1) ? $clog2(n_pheno) : 1;
      return data_width + extra;
   endfunction

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned cell_idx(input int unsigned g,
                                            input int unsigned p,
                                            input int unsigned n_geno);
      return g + n_geno * p;
   endfunction

   function automatic int unsigned out_idx(input int unsigned g,
                                           input int unsigned p,
                                           input int unsigned n_pheno);
      return g * n_pheno + p;
   endfunction

endpackage

// File: rtl/seq_frac_divider.sv
// Restoring long divider: one integer bit then FRAC_BITS fraction bits, one per cycle.
// A zero divisor runs the same number of cycles and yields a zero quotient.
module seq_frac_divider
   import pca_pkg::*;
#(
   parameter int unsigned NUM_WIDTH = 16,
   parameter int unsigned DEN_WIDTH = 17,
   parameter int unsigned FRAC_BITS = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [NUM_WIDTH-1:0] num,
   input  logic [DEN_WIDTH-1:0] den,
   output logic                 done,
   output logic [FRAC_BITS:0]   quot
);

   localparam int unsigned RW = DEN_WIDTH + 1;
   localparam int unsigned CW = idx_width(FRAC_BITS + 1);

   logic [RW-1:0]        rem_q, shifted, rem_next;
   logic [DEN_WIDTH-1:0] den_q;
   logic [FRAC_BITS:0]   q_q, q_next;
   logic [CW-1:0]        cnt_q;
   logic                 busy_q;
   logic                 ge;

   // The remainder stays below the divisor after the first step, so one
   // extra bit absorbs the left shift.
   always_comb begin
      shifted  = (cnt_q == '0) ? rem_q : {rem_q[RW-2:0], 1'b0};
      ge       = (shifted >= {1'b0, den_q});
      rem_next = ge ? (shifted - {1'b0, den_q}) : shifted;
      q_next   = {q_q[FRAC_BITS-1:0], ge};
      done     = busy_q && (cnt_q == CW'(FRAC_BITS));
      quot     = (den_q == '0) ? '0 : q_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_q  <= '0;
         den_q  <= '0;
         q_q    <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (load) begin
         rem_q  <= RW'(num);
         den_q  <= den;
         q_q    <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b1;
      end else if (busy_q) begin
         rem_q <= rem_next;
         q_q   <= q_next;
         cnt_q <= cnt_q + 1'b1;
         if (done) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/pca_prob_engine.sv
// P(pheno | geno) from an N_PHENO x N_GENO count table, one shared divider
// walking every cell; results are published together when the table is done.
module pca_prob_engine
   import pca_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned RESULT_WIDTH = 32,
   parameter int unsigned N_GENO       = 3,
   parameter int unsigned N_PHENO      = 2,
   parameter int unsigned FRAC_BITS    = 16
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [N_PHENO*N_GENO*DATA_WIDTH-1:0]   table_in,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   output logic [N_GENO*N_PHENO*RESULT_WIDTH-1:0] prob_out,
   output logic [N_GENO-1:0]                      div_zero,
   output logic                                   out_valid,
   input  logic                                   out_ready
);

   localparam int unsigned N_CELLS = N_GENO * N_PHENO;
   localparam int unsigned SW      = sum_width(DATA_WIDTH, N_PHENO);
   localparam int unsigned KW      = idx_width(N_CELLS);
   localparam int unsigned GW      = idx_width(N_GENO);
   localparam int unsigned PW      = idx_width(N_PHENO);

   state_t state_q, state_d;

   logic [DATA_WIDTH-1:0]   tbl_q     [N_CELLS];
   logic [SW-1:0]           col_sum_q [N_GENO];
   logic [SW-1:0]           col_sum_c [N_GENO];
   logic [RESULT_WIDTH-1:0] res_q     [N_CELLS];
   logic [RESULT_WIDTH-1:0] prob_q    [N_CELLS];
   logic [N_GENO-1:0]       dz_q, div_zero_q;
   logic [KW-1:0]           k_q;
   logic [GW-1:0]           g_q;
   logic [PW-1:0]           p_q;
   logic                    in_ready_q, out_valid_q;

   logic [DATA_WIDTH-1:0]   cell_sel;
   logic [SW-1:0]           den_sel;
   logic                    div_load, div_done, last_cell;
   logic [FRAC_BITS:0]      div_quot;

   always_comb begin
      for (int unsigned g = 0; g < N_GENO; g++) begin
         col_sum_c[g] = '0;
         for (int unsigned p = 0; p < N_PHENO; p++)
            col_sum_c[g] = col_sum_c[g] + SW'(tbl_q[cell_idx(g, p, N_GENO)]);
      end
   end

   always_comb begin
      cell_sel = '0;
      den_sel  = '0;
      for (int unsigned g = 0; g < N_GENO; g++) begin
         if (g_q == GW'(g)) den_sel = col_sum_q[g];
         for (int unsigned p = 0; p < N_PHENO; p++)
            if (g_q == GW'(g) && p_q == PW'(p))
               cell_sel = tbl_q[cell_idx(g, p, N_GENO)];
      end
   end

   assign last_cell = (k_q == KW'(N_CELLS - 1));

   always_comb begin
      state_d  = state_q;
      div_load = 1'b0;
      case (state_q)
         ST_IDLE: if (in_valid && in_ready_q) state_d = ST_SUM;
         ST_SUM:  state_d = ST_LOAD;
         ST_LOAD: begin
            div_load = 1'b1;
            state_d  = ST_ITER;
         end
         ST_ITER: if (div_done) state_d = last_cell ? ST_OUT : ST_LOAD;
         ST_OUT:  if (out_valid_q && out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < N_CELLS; i++) begin
            tbl_q[i]  <= '0;
            res_q[i]  <= '0;
            prob_q[i] <= '0;
         end
         for (int unsigned g = 0; g < N_GENO; g++) col_sum_q[g] <= '0;
         dz_q        <= '0;
         div_zero_q  <= '0;
         k_q         <= '0;
         g_q         <= '0;
         p_q         <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         in_ready_q <= (state_d == ST_IDLE);
         case (state_q)
            ST_IDLE: if (in_valid && in_ready_q)
               for (int unsigned i = 0; i < N_CELLS; i++)
                  tbl_q[i] <= table_in[i*DATA_WIDTH +: DATA_WIDTH];
            ST_SUM: begin
               for (int unsigned g = 0; g < N_GENO; g++) begin
                  col_sum_q[g] <= col_sum_c[g];
                  dz_q[g]      <= (col_sum_c[g] == '0);
               end
               k_q <= '0;
               g_q <= '0;
               p_q <= '0;
            end
            ST_ITER: if (div_done) begin
               res_q[k_q] <= RESULT_WIDTH'(div_quot);
               if (!last_cell) begin
                  k_q <= k_q + 1'b1;
                  if (p_q == PW'(N_PHENO - 1)) begin
                     p_q <= '0;
                     g_q <= g_q + 1'b1;
                  end else begin
                     p_q <= p_q + 1'b1;
                  end
               end
            end
            // First OUT cycle publishes the finished table; results only
            // ever change here, so prob_out never shows a partial table.
            ST_OUT: begin
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
                  div_zero_q  <= dz_q;
                  for (int unsigned i = 0; i < N_CELLS; i++) prob_q[i] <= res_q[i];
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   seq_frac_divider #(
      .NUM_WIDTH (DATA_WIDTH),
      .DEN_WIDTH (SW),
      .FRAC_BITS (FRAC_BITS)
   ) u_div (
      .clk  (clk),
      .rst  (rst),
      .load (div_load),
      .num  (cell_sel),
      .den  (den_sel),
      .done (div_done),
      .quot (div_quot)
   );

   always_comb begin
      prob_out = '0;
      for (int unsigned i = 0; i < N_CELLS; i++)
         prob_out[i*RESULT_WIDTH +: RESULT_WIDTH] = prob_q[i];
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_pca_prob_engine.sv
// Bench for pca_prob_engine: vector table with scoreboard, plus stall,
// back-to-back, reset-abort and a 4x3 / 8-fraction-bit instance.
module tb_pca_prob_engine;
   import pca_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic [95:0]  table_in;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [191:0] prob_out;
   logic [2:0]   div_zero;

   logic [191:0] table2;
   logic         in_valid2, in_ready2, out_valid2, out_ready2;
   logic [383:0] prob2;
   logic [3:0]   dz2;

   always #5 clk = ~clk;

   pca_prob_engine #(
      .DATA_WIDTH(16), .RESULT_WIDTH(32), .N_GENO(3), .N_PHENO(2), .FRAC_BITS(16)
   ) dut (
      .clk(clk), .rst(rst), .table_in(table_in), .in_valid(in_valid),
      .in_ready(in_ready), .prob_out(prob_out), .div_zero(div_zero),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   pca_prob_engine #(
      .DATA_WIDTH(16), .RESULT_WIDTH(32), .N_GENO(4), .N_PHENO(3), .FRAC_BITS(8)
   ) dut2 (
      .clk(clk), .rst(rst), .table_in(table2), .in_valid(in_valid2),
      .in_ready(in_ready2), .prob_out(prob2), .div_zero(dz2),
      .out_valid(out_valid2), .out_ready(out_ready2)
   );

   typedef struct {
      logic [95:0]  tbl;
      logic [191:0] prob;
      logic [2:0]   dz;
   } vec_t;

   typedef struct {
      logic [191:0] prob;
      logic [2:0]   dz;
      int           acc;
   } exp_t;

   exp_t sb[$];
   vec_t v[6];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   last_acc = 0;
   logic prev_ov = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [95:0] mk_tbl(input logic [15:0] g0p0, g0p1, g1p0, g1p1, g2p0, g2p1);
      logic [95:0] t;
      t = '0;
      t[cell_idx(0, 0, 3)*16 +: 16] = g0p0;
      t[cell_idx(0, 1, 3)*16 +: 16] = g0p1;
      t[cell_idx(1, 0, 3)*16 +: 16] = g1p0;
      t[cell_idx(1, 1, 3)*16 +: 16] = g1p1;
      t[cell_idx(2, 0, 3)*16 +: 16] = g2p0;
      t[cell_idx(2, 1, 3)*16 +: 16] = g2p1;
      return t;
   endfunction

   function automatic logic [191:0] mk_prob(input logic [31:0] r0, r1, r2, r3, r4, r5);
      return {r5, r4, r3, r2, r1, r0};
   endfunction

   // Reference: floor(cell * 2^16 / column_sum), zero when the column is empty.
   function automatic void model(input logic [95:0] t, output logic [191:0] pr, output logic [2:0] dz);
      longint s, c;
      pr = '0;
      dz = '0;
      for (int g = 0; g < 3; g++) begin
         s = 0;
         for (int p = 0; p < 2; p++) s += longint'(t[cell_idx(g, p, 3)*16 +: 16]);
         dz[g] = (s == 0);
         for (int p = 0; p < 2; p++) begin
            c = longint'(t[cell_idx(g, p, 3)*16 +: 16]);
            pr[out_idx(g, p, 2)*32 +: 32] = (s == 0) ? 32'd0 : 32'((c << 16) / s);
         end
      end
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (out_valid && !prev_ov) begin
         if (sb.size() == 0) begin
            chk("unexpected_out_valid", 512'(out_valid), 512'(0));
         end else begin
            e = sb.pop_front();
            chk("latency", 512'(cyc - e.acc), 512'(110));
            chk("prob_out", 512'(prob_out), 512'(e.prob));
            chk("div_zero", 512'(div_zero), 512'(e.dz));
         end
      end
      prev_ov = out_valid;
   end

   task automatic send(input vec_t vec, input bit hold);
      exp_t e;
      bit   got;
      table_in = vec.tbl;
      in_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         if (in_ready) got = 1'b1;
      end
      if (!got) begin
         chk("accept_timeout", 512'(in_ready), 512'(1));
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         last_acc = cyc;
         e.prob = vec.prob;
         e.dz   = vec.dz;
         e.acc  = cyc;
         sb.push_back(e);
         if (!hold) in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         chk("drain_timeout", 512'(sb.size()), 512'(0));
         sb.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [191:0] cap;
      logic [2:0]   capd;
      bit           stable, seen;
      int           acc_a, acc2;
      logic [191:0] exp2_tbl;
      logic [383:0] exp2_prob;

      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; table_in = '0;
      in_valid2 = 1'b0; out_ready2 = 1'b1; table2 = '0;

      v[0].tbl = mk_tbl(16'd3, 16'd1, 16'd0, 16'd0, 16'd5, 16'd0);
      v[0].prob = mk_prob(32'hC000, 32'h4000, 32'h0, 32'h0, 32'h10000, 32'h0);
      v[0].dz = 3'b010;
      v[1].tbl = {6{16'hFFFF}};
      v[1].prob = {6{32'h8000}};
      v[1].dz = 3'b000;
      v[2].tbl = mk_tbl(16'd1, 16'hFFFF, 16'd0, 16'd7, 16'hFFFF, 16'd0);
      v[2].prob = mk_prob(32'h1, 32'hFFFF, 32'h0, 32'h10000, 32'h10000, 32'h0);
      v[2].dz = 3'b000;
      for (int i = 3; i < 6; i++) begin
         logic [15:0] c[6];
         for (int j = 0; j < 6; j++)
            c[j] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 2));
         v[i].tbl = mk_tbl(c[0], c[1], c[2], c[3], c[4], c[5]);
         model(v[i].tbl, v[i].prob, v[i].dz);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 512'(in_ready), 512'(0));
      chk("rst_out_valid", 512'(out_valid), 512'(0));
      chk("rst_prob_out", 512'(prob_out), 512'(0));
      chk("rst_div_zero", 512'(div_zero), 512'(0));
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      chk("in_ready_after_rst", 512'(in_ready), 512'(1));

      for (int i = 0; i < 6; i++) begin
         send(v[i], 1'b0);
         drain();
      end

      // Stall with out_ready low for 20 cycles.
      out_ready = 1'b0;
      send(v[3], 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("stall_out_valid_seen", 512'(seen), 512'(1));
      cap = prob_out;
      capd = div_zero;
      stable = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (!out_valid || prob_out !== cap || div_zero !== capd || in_ready) stable = 1'b0;
      end
      chk("stall_stable", 512'(stable), 512'(1));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("release_out_valid", 512'(out_valid), 512'(0));
      chk("release_in_ready", 512'(in_ready), 512'(1));
      drain();

      // Back-to-back with in_valid held high.
      send(v[1], 1'b1);
      acc_a = last_acc;
      send(v[0], 1'b0);
      chk("b2b_accept_gap", 512'(last_acc - acc_a), 512'(112));
      drain();

      // Reset during ITER of cell 3, then a clean table.
      send(v[2], 1'b0);
      repeat (60) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("abort_out_valid", 512'(out_valid), 512'(0));
      chk("abort_prob_out", 512'(prob_out), 512'(0));
      chk("abort_div_zero", 512'(div_zero), 512'(0));
      chk("abort_in_ready", 512'(in_ready), 512'(0));
      sb.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      send(v[4], 1'b0);
      drain();

      // 4 genotypes x 3 phenotypes, 8 fraction bits.
      exp2_tbl = '0;
      exp2_tbl[cell_idx(1, 0, 4)*16 +: 16] = 16'd1;
      exp2_tbl[cell_idx(1, 1, 4)*16 +: 16] = 16'd1;
      exp2_tbl[cell_idx(1, 2, 4)*16 +: 16] = 16'd2;
      exp2_tbl[cell_idx(2, 0, 4)*16 +: 16] = 16'd3;
      exp2_tbl[cell_idx(3, 0, 4)*16 +: 16] = 16'd1;
      exp2_tbl[cell_idx(3, 1, 4)*16 +: 16] = 16'd2;
      exp2_tbl[cell_idx(3, 2, 4)*16 +: 16] = 16'd3;
      exp2_prob = {32'h80, 32'h55, 32'h2A, 32'h0, 32'h0, 32'h100,
                   32'h80, 32'h40, 32'h40, 32'h0, 32'h0, 32'h0};
      table2 = exp2_tbl;
      in_valid2 = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (in_ready2) seen = 1'b1;
      end
      chk("sweep_in_ready", 512'(seen), 512'(1));
      @(posedge clk);
      #1;
      acc2 = cyc;
      in_valid2 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (out_valid2) seen = 1'b1;
      end
      chk("sweep_out_valid_seen", 512'(seen), 512'(1));
      chk("sweep_latency", 512'(cyc - acc2), 512'(122));
      chk("sweep_prob_out", 512'(prob2), 512'(exp2_prob));
      chk("sweep_div_zero", 512'(dz2), 512'(4'b0001));
      @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pca_prob_engine.md
Name: pca_prob_engine

Overview:
- Computes conditional genotype/phenotype probabilities P(pheno | geno) from a margin (contingency) table of N_PHENO x N_GENO counts, in fixed point.
- Generalised successor to the fixed 2x3 parallel-divider calculator.
- Uses one shared iterative divider, valid/ready handshakes on both sides and an explicit divide-by-zero flag.
- Sits between the margin-table accumulator and the statistic scorer in the boost pipeline.

Parameters:
- DATA_WIDTH, 16: width of each table count.
- RESULT_WIDTH, 32: width of each probability output. Must satisfy RESULT_WIDTH >= FRAC_BITS+1.
- N_GENO, 3: genotype classes (table columns).
- N_PHENO, 2: phenotype classes (table rows).
- FRAC_BITS, 16: fractional bits of the result. 1.0 is represented as 1<<FRAC_BITS.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- table_in  in  N_PHENO*N_GENO*DATA_WIDTH  counts. Cell (p,g) is at slice index g+N_GENO*p.
- in_valid  in  1  table_in valid.
- in_ready  out  1  engine idle and able to accept a table.
- prob_out  out  N_GENO*N_PHENO*RESULT_WIDTH  probabilities. Result (g,p) is at slice index k=g*N_PHENO+p.
- div_zero  out  N_GENO  bit g set when column g sums to 0.
- out_valid  out  1  prob_out and div_zero valid.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst low (asynchronous) forces state IDLE and clears all registers.
  - Reset values: in_ready=0 while rst is low, then 1 from the first clock edge after release. out_valid=0, prob_out=0, div_zero=0.
  - Reset mid-computation aborts the table; no partial result is ever presented.
- States: IDLE, SUM, LOAD, ITER, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready the table is latched and the FSM goes to SUM. Accepting edge = T.
- SUM (1 cycle):
  - col_sum[g] = sum over p of cell(p,g), width DATA_WIDTH+$clog2(N_PHENO) (minimum 1 extra bit). No overflow is possible.
  - div_zero[g] is registered here as col_sum[g]==0.
  - Cell counter k is cleared; next state LOAD.
- LOAD (1 cycle):
  - Divider is loaded with remainder = cell(p,g) and divisor = col_sum[g], where g=k/N_PHENO and p=k%N_PHENO.
  - Next state ITER.
- ITER (FRAC_BITS+1 cycles), restoring long division:
  - First iteration produces the integer bit (rem>=div). Each later iteration does rem<<=1 and produces one fraction bit.
  - Since cell<=col_sum, the quotient is <=1<<FRAC_BITS. It is zero-extended into slot k.
  - If divisor==0, the divider still runs the same cycle count but the result is forced to 0. Latency is data-independent.
  - When the last iteration completes: if k==N_GENO*N_PHENO-1 go to OUT, else k++ and go to LOAD.
  - Truncating division: no rounding.
- OUT:
  - out_valid=1. prob_out and div_zero are held stable while out_valid&&!out_ready.
  - On out_ready, out_valid drops the next cycle and the FSM returns to IDLE (in_ready=1 that cycle). No same-cycle re-accept.
- Latency: out_valid rises exactly 2+N_CELLS*(FRAC_BITS+2) cycles after T, where N_CELLS=N_GENO*N_PHENO. Defaults give 110.
- Throughput: one table per latency+2 cycles with out_ready held high.
- in_valid while busy is ignored, since in_ready=0. The upstream must hold table_in until accepted.
- prob_out retains the previous result in IDLE/SUM/LOAD/ITER; only out_valid qualifies it.

Decomposition:
- Shared package pca_pkg:
  - FSM state enum.
  - Function for the column-sum width.
  - Function for the index maps: cell index g+N_GENO*p, output index g*N_PHENO+p.
  - Constant ONE = 1<<FRAC_BITS.
- Sub-module seq_frac_divider: load/start, done, FRAC_BITS+1 iterations, zero-divisor forcing.
- The top level holds the FSM, sums, counter and output register.

Test Plan (defaults, counts listed as case/control per genotype):
- Genotype 0 = 3/1, genotype 1 = 0/0, genotype 2 = 5/0 -> prob_out = {0xC000, 0x4000, 0, 0, 0x10000, 0}, div_zero = 3'b010, out_valid at T+110.
- All counts 0xFFFF -> every output 0x8000, div_zero = 0.
- Hold out_ready=0 for 20 cycles after out_valid -> outputs stable, in_ready=0; release -> out_valid low next cycle, in_ready=1.
- Back-to-back tables with in_valid held high and out_ready=1 -> second table accepted on the first IDLE cycle, second result correct, no cross-contamination.
- Assert rst low during ITER of cell 3 -> all outputs 0 immediately. After release a new table yields a correct result with the full 110-cycle latency.
- Parameter sweep N_GENO=4, N_PHENO=3, FRAC_BITS=8: column 1/1/2 -> 0x40, 0x40, 0x80, latency 2+12*10=122.
